// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: serializes a WIDTH-bit word onto one line, MSB first,
// one bit per clock, behind a valid/ready load handshake. Line idles high.
//
// Optional feature macro: SERIAL_PATTERN_TX_PREAMBLE_EN
//   defined   -> every word is preceded by a 0,1,0 sync preamble (PRE state)
//   undefined -> IDLE goes straight to SHIFT; PRE encoding left unused
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset, forces IDLE
//   data   in   [WIDTH-1:0] parallel word, sampled on the accepting edge
//   load   in   word valid
//   ready  out  high only in IDLE; accept on load && ready
//   out    out  serial line, 1 when idle
//   busy   out  high in PRE, SHIFT and DONE
//   done   out  one-cycle pulse after the last payload bit
module serial_pattern_tx #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    output logic             ready,
    output logic             out,
    output logic             busy,
    output logic             done
);

    // One extra bit so the counter never wraps inside a word.
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRE   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             accept_c;

    assign accept_c = load && ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept_c) begin
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
                    state_nxt = S_PRE;
`else
                    state_nxt = S_SHIFT;
`endif
                end
            end
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
            S_PRE: begin
                if (cnt == CW'(2)) begin
                    state_nxt = S_SHIFT;
                end
            end
`endif
            S_SHIFT: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state only.
    always_comb begin
        out   = 1'b1;
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
            end
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
            S_PRE: begin
                busy = 1'b1;
                // Preamble 0,1,0: only the middle slot is high.
                out  = (cnt == CW'(1));
            end
`endif
            S_SHIFT: begin
                busy = 1'b1;
                out  = sreg[WIDTH-1];
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                out = 1'b1;
            end
        endcase
    end

    // Shift register and bit counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg <= '0;
            cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        sreg <= data;
                        cnt  <= '0;
                    end
                end
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
                S_PRE: begin
                    // Cleared on the last preamble slot so SHIFT starts at 0.
                    if (cnt == CW'(2)) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                S_SHIFT: begin
                    sreg <= {sreg[WIDTH-2:0], 1'b0};
                    cnt  <= cnt + CW'(1);
                end
                default: begin
                    sreg <= sreg;
                    cnt  <= cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: a WIDTH=8 and a WIDTH=2 instance.
// Stimulus pushes the expected per-cycle line/done values of each accepted
// word; monitors pop one entry per busy cycle and check idle values otherwise.
module tb_serial_pattern_tx;

`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
    localparam int unsigned PRE_LEN = 3;
`else
    localparam int unsigned PRE_LEN = 0;
`endif
    localparam int unsigned P8 = 8 + 2 + PRE_LEN;
    localparam int unsigned P2 = 2 + 2 + PRE_LEN;

    typedef struct packed {
        logic o;
        logic d;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] data8;
    logic       load8;
    logic       ready8, out8, busy8, done8;
    logic [1:0] data2;
    logic       load2;
    logic       ready2, out2, busy2, done2;

    int checks;
    int failures;

    exp_t q8[$];
    exp_t q2[$];

    serial_pattern_tx #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .data(data8), .load(load8),
        .ready(ready8), .out(out8), .busy(busy8), .done(done8)
    );

    serial_pattern_tx #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .data(data2), .load(load2),
        .ready(ready2), .out(out2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic o, input logic d);
        exp_t e;
        e.o = o;
        e.d = d;
        return e;
    endfunction

    function automatic void push8(input logic [7:0] w);
        if (PRE_LEN != 0) begin
            q8.push_back(mk(1'b0, 1'b0));
            q8.push_back(mk(1'b1, 1'b0));
            q8.push_back(mk(1'b0, 1'b0));
        end
        for (int i = 7; i >= 0; i--) q8.push_back(mk(w[i], 1'b0));
        q8.push_back(mk(1'b1, 1'b1));
    endfunction

    function automatic void push2(input logic [1:0] w);
        if (PRE_LEN != 0) begin
            q2.push_back(mk(1'b0, 1'b0));
            q2.push_back(mk(1'b1, 1'b0));
            q2.push_back(mk(1'b0, 1'b0));
        end
        for (int i = 1; i >= 0; i--) q2.push_back(mk(w[i], 1'b0));
        q2.push_back(mk(1'b1, 1'b1));
    endfunction

    // Monitor for the WIDTH=8 instance.
    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (busy8 === 1'b1) begin
            if (q8.size() == 0) begin
                failures++;
                $display("FAIL dut8_unexpected_busy t=%0t: busy=1 out=%b done=%b, required busy=0", $time, out8, done8);
            end else begin
                e = q8.pop_front();
                if (out8 !== e.o || done8 !== e.d || ready8 !== 1'b0) begin
                    failures++;
                    $display("FAIL dut8_word t=%0t: out=%b done=%b ready=%b, required out=%b done=%b ready=0",
                             $time, out8, done8, ready8, e.o, e.d);
                end
            end
        end else begin
            if (out8 !== 1'b1 || ready8 !== 1'b1 || done8 !== 1'b0 || busy8 !== 1'b0 || q8.size() != 0) begin
                failures++;
                $display("FAIL dut8_idle t=%0t: out=%b ready=%b done=%b busy=%b pending=%0d, required 1 1 0 0 pending=0",
                         $time, out8, ready8, done8, busy8, q8.size());
                q8.delete();
            end
        end
    end

    // Monitor for the WIDTH=2 instance.
    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (busy2 === 1'b1) begin
            if (q2.size() == 0) begin
                failures++;
                $display("FAIL dut2_unexpected_busy t=%0t: busy=1 out=%b done=%b, required busy=0", $time, out2, done2);
            end else begin
                e = q2.pop_front();
                if (out2 !== e.o || done2 !== e.d || ready2 !== 1'b0) begin
                    failures++;
                    $display("FAIL dut2_word t=%0t: out=%b done=%b ready=%b, required out=%b done=%b ready=0",
                             $time, out2, done2, ready2, e.o, e.d);
                end
            end
        end else begin
            if (out2 !== 1'b1 || ready2 !== 1'b1 || done2 !== 1'b0 || busy2 !== 1'b0 || q2.size() != 0) begin
                failures++;
                $display("FAIL dut2_idle t=%0t: out=%b ready=%b done=%b busy=%b pending=%0d, required 1 1 0 0 pending=0",
                         $time, out2, ready2, done2, busy2, q2.size());
                q2.delete();
            end
        end
    end

    // Accept one word on the next edge and wait for the full word period.
    task automatic send8(input logic [7:0] w);
        @(posedge clk);
        #1 data8 = w;
        load8 = 1'b1;
        @(posedge clk);
        push8(w);
        #1 load8 = 1'b0;
        data8 = ~w;
        repeat (P8) @(posedge clk);
    endtask

    task automatic send2(input logic [1:0] w);
        @(posedge clk);
        #1 data2 = w;
        load2 = 1'b1;
        @(posedge clk);
        push2(w);
        #1 load2 = 1'b0;
        data2 = ~w;
        repeat (P2) @(posedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        data8    = '0;
        load8    = 1'b0;
        data2    = '0;
        load2    = 1'b0;

        // Reset hold then idle cycles with load low.
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);

        send8(8'hA5);
        send8(8'hFF);

        // Continuous load with data changing every cycle.
        @(posedge clk);
        #1 data8 = 8'h01;
        load8 = 1'b1;
        for (int c = 0; c < 3 * int'(P8); c++) begin
            @(posedge clk);
            if (c % int'(P8) == 0) push8(8'(c + 1));
            #1 data8 = 8'(c + 2);
        end
        load8 = 1'b0;
        repeat (3) @(posedge clk);

        // Reset asserted between edges during payload bit 3.
        @(posedge clk);
        #1 data8 = 8'hC3;
        load8 = 1'b1;
        @(posedge clk);
        push8(8'hC3);
        #1 load8 = 1'b0;
        data8 = 8'h00;
        repeat (PRE_LEN + 3) @(posedge clk);
        #2 reset = 1'b1;
        q8.delete();
        #1;
        checks++;
        if (out8 !== 1'b1 || ready8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: out=%b ready=%b busy=%b done=%b, required 1 1 0 0",
                     out8, ready8, busy8, done8);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        send8(8'h3C);

        // Minimum width.
        send2(2'b10);
        send2(2'b01);

        repeat (5) @(posedge clk);
        checks++;
        if (q8.size() != 0 || q2.size() != 0) begin
            failures++;
            $display("FAIL drain: pending8=%0d pending2=%0d, required 0 0", q8.size(), q2.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
